// File: rtl/uart_tx_serializer.sv
// UART TX framer: start, DATA_WIDTH bits LSB first, optional parity (UART_TX_PARITY_EN), stop.
// Latency: start bit on tx_out from the acceptance edge; frame is 2+DATA_WIDTH(+1) cycles.
// Backpressure: data_valid is level-sampled in IDLE only; busy high while a frame is on the line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_en_q;
    logic par_typ_q;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    logic unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  accept;
    logic                  tx_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
            end
            DATA: begin
                if (cnt == CW'(DATA_WIDTH - 1)) begin
                    cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en_q ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_nxt = STOP;
`endif
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START: tx_nxt = 1'b0;
            DATA:  tx_nxt = data_q[cnt_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nxt = (^data_q) ^ par_typ_q;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            tx_out <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            tx_out <= tx_nxt;
            busy   <= (state_nxt != IDLE);
            if (accept) begin
                data_q <= p_data;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: vector table, hand-written corner cases, random frames.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".tx"}, tx_out, 1'b1);
        chk({nm, ".busy"}, busy, 1'b0);
    endtask

    // Caller presents d/pe/pt with data_valid=1; the next edge is the acceptance edge.
    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic pt,
                                input logic exp_par, input logic hold,
                                input logic [7:0] nd, input string nm);
        logic exp_bits[12];
        int   len;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = d[i];
        len = 9;
        if (pe && PAR_BUILT) begin
            exp_bits[len] = exp_par;
            len++;
        end
        exp_bits[len] = 1'b1;
        len++;
        for (int k = 0; k < len; k++) begin
            tick();
            if (k == 0) begin
                if (hold) p_data = nd;
                else data_valid = 1'b0;
            end
            if (!hold) begin
                p_data  = 8'($urandom);
                par_en  = 1'($urandom);
                par_typ = 1'($urandom);
            end
            chk($sformatf("%s.bit%0d.tx", nm, k), tx_out, exp_bits[k]);
            chk($sformatf("%s.bit%0d.busy", nm, k), busy, 1'b1);
        end
        tick();
        chk_idle({nm, ".end"});
    endtask

    task automatic present(input logic [7:0] d, input logic pe, input logic pt);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1};

        // Reset together with a request: reset wins, nothing captured.
        rst = 1'b1;
        present(8'hA5, 1'b1, 1'b0);
        #1;
        chk_idle("rst_async");
        tick();
        tick();
        chk_idle("rst_with_valid");
        data_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle($sformatf("post_rst%0d", i));
        end

        // Reset pulse while idle produces no frame.
        rst = 1'b1;
        tick();
        chk_idle("idle_rst_hi");
        rst = 1'b0;
        tick();
        tick();
        chk_idle("idle_rst_lo");

        for (int v = 0; v < 6; v++) begin
            present(vecs[v].data, vecs[v].pe, vecs[v].pt);
            expect_frame(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].exp_par,
                         1'b0, 8'h00, $sformatf("vec%0d", v));
        end

        // Back-to-back with data_valid held: one idle cycle between frames.
        present(8'hA5, 1'b1, 1'b0);
        expect_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, "b2b_a");
        expect_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "b2b_b");

        // Reset during data bit 3 returns the line high immediately.
        present(8'hA5, 1'b1, 1'b0);
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rst.pre_tx", tx_out, 1'b0);
        rst = 1'b1;
        #1;
        chk_idle("mid_rst.now");
        tick();
        chk_idle("mid_rst.hold");
        rst = 1'b0;
        tick();
        chk_idle("mid_rst.release");
        present(8'h5A, 1'b1, 1'b1);
        expect_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "after_rst");

        // Random frames against the model: parity = popcount(data) mod 2, inverted for odd.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            int         gap;
            d   = 8'($urandom);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                data_valid = 1'b0;
                tick();
                chk_idle($sformatf("rnd%0d.gap%0d", n, g));
            end
            present(d, pe, pt);
            expect_frame(d, pe, pt, 1'(($countones(d) % 2) != 0) ^ pt, 1'b0, 8'h00,
                         $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
